// File: rtl/riscvvec_lane_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : riscvvec_lane_mem_responder
//  Brief    : Eight-lane word-indexed data memory. One shared request valid,
//             one fixed-latency response per lane. Optional out-of-range
//             checking is enabled by defining RISCVVEC_LANE_MEM_ERRCHK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module riscvvec_lane_mem_responder #(
    parameter int ENTRIES = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [66:0] memreq0_msg,
    input  logic [66:0] memreq1_msg,
    input  logic [66:0] memreq2_msg,
    input  logic [66:0] memreq3_msg,
    input  logic [66:0] memreq4_msg,
    input  logic [66:0] memreq5_msg,
    input  logic [66:0] memreq6_msg,
    input  logic [66:0] memreq7_msg,
    output logic [34:0] memresp0_msg,
    output logic [34:0] memresp1_msg,
    output logic [34:0] memresp2_msg,
    output logic [34:0] memresp3_msg,
    output logic [34:0] memresp4_msg,
    output logic [34:0] memresp5_msg,
    output logic [34:0] memresp6_msg,
    output logic [34:0] memresp7_msg,
    output logic        memresp0_val,
    output logic        memresp1_val,
    output logic        memresp2_val,
    output logic        memresp3_val,
    output logic        memresp4_val,
    output logic        memresp5_val,
    output logic        memresp6_val,
    output logic        memresp7_val,
    output logic        err_oob
);

    localparam int IW = $clog2(ENTRIES);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              accept;
    logic              resp_val;

    logic [7:0][66:0]  req_msg;
    logic [7:0][34:0]  resp_msg;
    logic [7:0][IW-1:0] idx;
    logic [7:0]        is_wr;
    logic [7:0]        oob;
    logic [7:0][31:0]  wr_word;
    logic [7:0][31:0]  rd_word;

    logic [31:0]       mem [ENTRIES];

    assign req_msg[0] = memreq0_msg;
    assign req_msg[1] = memreq1_msg;
    assign req_msg[2] = memreq2_msg;
    assign req_msg[3] = memreq3_msg;
    assign req_msg[4] = memreq4_msg;
    assign req_msg[5] = memreq5_msg;
    assign req_msg[6] = memreq6_msg;
    assign req_msg[7] = memreq7_msg;

    assign memresp0_msg = resp_msg[0];
    assign memresp1_msg = resp_msg[1];
    assign memresp2_msg = resp_msg[2];
    assign memresp3_msg = resp_msg[3];
    assign memresp4_msg = resp_msg[4];
    assign memresp5_msg = resp_msg[5];
    assign memresp6_msg = resp_msg[6];
    assign memresp7_msg = resp_msg[7];

    assign memresp0_val = resp_val;
    assign memresp1_val = resp_val;
    assign memresp2_val = resp_val;
    assign memresp3_val = resp_val;
    assign memresp4_val = resp_val;
    assign memresp5_val = resp_val;
    assign memresp6_val = resp_val;
    assign memresp7_val = resp_val;

    // Ready is gated by reset directly so nothing is accepted while it is held.
    assign memreq_rdy = reset && (state == IDLE);
    assign accept     = memreq_val && memreq_rdy;
    assign resp_val   = (state == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY > 1) begin
                        state_next = WAIT;
                        count_next = CNT_LOAD;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            WAIT: begin
                if (count == '0) begin
                    state_next = RESP;
                end else begin
                    count_next = count - CW'(1);
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    for (genvar l = 0; l < 8; l++) begin : g_lane
        logic [31:0] old_word;
        logic [31:0] new_data;
        logic [1:0]  len;

        assign idx[l]   = req_msg[l][34+IW-1:34];
        assign is_wr[l] = req_msg[l][66];
        assign len      = req_msg[l][33:32];
        assign new_data = req_msg[l][31:0];
        assign old_word = mem[idx[l]];

`ifdef RISCVVEC_LANE_MEM_ERRCHK_EN
        assign oob[l] = |req_msg[l][65:34+IW];
`else
        logic unused_hi;
        assign oob[l]    = 1'b0;
        assign unused_hi = ^req_msg[l][65:34+IW];
`endif

        // Partial writes merge the low bytes into the pre-transaction word.
        assign wr_word[l] = (len == 2'd1) ? {old_word[31:8],  new_data[7:0]}  :
                            (len == 2'd2) ? {old_word[31:16], new_data[15:0]} :
                            (len == 2'd3) ? {old_word[31:24], new_data[23:0]} :
                                            new_data;
        assign rd_word[l] = oob[l] ? 32'hDEAD_BEEF : old_word;
    end

    // Ascending lane order: the highest-numbered writer's assignment wins.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int l = 0; l < 8; l++) begin
                if (is_wr[l] && !oob[l]) begin
                    mem[idx[l]] <= wr_word[l];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_msg <= '0;
        end else if (accept) begin
            for (int l = 0; l < 8; l++) begin
                resp_msg[l] <= {is_wr[l], req_msg[l][33:32], is_wr[l] ? 32'h0 : rd_word[l]};
            end
        end
    end

`ifdef RISCVVEC_LANE_MEM_ERRCHK_EN
    logic err_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_flag <= 1'b0;
        end else if (accept && (|oob)) begin
            err_flag <= 1'b1;
        end
    end

    assign err_oob = err_flag;
`else
    assign err_oob = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscvvec_lane_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscvvec_lane_mem_responder
//  Brief    : Self-checking bench: directed scenarios plus randomized traffic
//             against a transaction-level memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscvvec_lane_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1_n, val1, rdy1, err1;
    logic [66:0] req1  [8];
    logic [34:0] resp1 [8];
    logic [7:0]  rv1;

    logic        rst4_n, val4, rdy4, err4;
    logic [66:0] req4  [8];
    logic [34:0] resp4 [8];
    logic [7:0]  rv4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl [256];
    logic        model_err = 1'b0;
    logic [34:0] exp_msg [8];

    logic [34:0] got  [8];
    logic [34:0] held [8];
    logic [7:0]  gval, hval;
    logic        rdy_at_req, rdy_in_resp;

    riscvvec_lane_mem_responder #(.ENTRIES(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst1_n), .memreq_val(val1), .memreq_rdy(rdy1),
        .memreq0_msg(req1[0]), .memreq1_msg(req1[1]), .memreq2_msg(req1[2]), .memreq3_msg(req1[3]),
        .memreq4_msg(req1[4]), .memreq5_msg(req1[5]), .memreq6_msg(req1[6]), .memreq7_msg(req1[7]),
        .memresp0_msg(resp1[0]), .memresp1_msg(resp1[1]), .memresp2_msg(resp1[2]), .memresp3_msg(resp1[3]),
        .memresp4_msg(resp1[4]), .memresp5_msg(resp1[5]), .memresp6_msg(resp1[6]), .memresp7_msg(resp1[7]),
        .memresp0_val(rv1[0]), .memresp1_val(rv1[1]), .memresp2_val(rv1[2]), .memresp3_val(rv1[3]),
        .memresp4_val(rv1[4]), .memresp5_val(rv1[5]), .memresp6_val(rv1[6]), .memresp7_val(rv1[7]),
        .err_oob(err1)
    );

    riscvvec_lane_mem_responder #(.ENTRIES(256), .LATENCY(4)) dut4 (
        .clk(clk), .reset(rst4_n), .memreq_val(val4), .memreq_rdy(rdy4),
        .memreq0_msg(req4[0]), .memreq1_msg(req4[1]), .memreq2_msg(req4[2]), .memreq3_msg(req4[3]),
        .memreq4_msg(req4[4]), .memreq5_msg(req4[5]), .memreq6_msg(req4[6]), .memreq7_msg(req4[7]),
        .memresp0_msg(resp4[0]), .memresp1_msg(resp4[1]), .memresp2_msg(resp4[2]), .memresp3_msg(resp4[3]),
        .memresp4_msg(resp4[4]), .memresp5_msg(resp4[5]), .memresp6_msg(resp4[6]), .memresp7_msg(resp4[7]),
        .memresp0_val(rv4[0]), .memresp1_val(rv4[1]), .memresp2_val(rv4[2]), .memresp3_val(rv4[3]),
        .memresp4_val(rv4[4]), .memresp5_val(rv4[5]), .memresp6_val(rv4[6]), .memresp7_val(rv4[7]),
        .err_oob(err4)
    );

    function automatic logic [66:0] mk(input logic t, input logic [31:0] a,
                                       input logic [1:0] len, input logic [31:0] d);
        return {t, a, len, d};
    endfunction

    // Transaction-level model: reads see the memory as it was before the
    // transaction; writes apply in lane order so the last writer wins.
    function automatic void model_txn();
        logic [31:0] snap [256];
        logic [31:0] addr, data, mask;
        logic [1:0]  len;
        logic        typ, bad;
        int          ix;
        snap = mdl;
        for (int l = 0; l < 8; l++) begin
            typ  = req1[l][66];
            addr = req1[l][65:34];
            len  = req1[l][33:32];
            data = req1[l][31:0];
            ix   = int'(addr % 256);
            bad  = 1'b0;
`ifdef RISCVVEC_LANE_MEM_ERRCHK_EN
            bad = (addr >= 32'd256);
`endif
            if (bad) model_err = 1'b1;
            if (typ == 1'b0) begin
                exp_msg[l] = {typ, len, bad ? 32'hDEAD_BEEF : snap[ix]};
            end else begin
                exp_msg[l] = {typ, len, 32'h0};
                mask = (len == 2'd0) ? 32'hFFFF_FFFF : (32'hFFFF_FFFF >> (32 - 8 * int'(len)));
                if (!bad) mdl[ix] = (snap[ix] & ~mask) | (data & mask);
            end
        end
    endfunction

    // One LATENCY=1 transaction on dut1; starts and ends on a falling edge.
    task automatic run1();
        model_txn();
        val1 = 1'b1;
        rdy_at_req = rdy1;
        @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 8; l++) got[l] = resp1[l];
        gval = rv1;
        rdy_in_resp = rdy1;
        val1 = 1'b0;
        @(negedge clk);
        for (int l = 0; l < 8; l++) held[l] = resp1[l];
        hval = rv1;
    endtask

    task automatic reads_around();
        for (int l = 0; l < 8; l++) req1[l] = mk(1'b0, 32'h10 + l, 2'd0, 32'h0);
    endtask

    task automatic test_reset();
        rst1_n = 1'b0; rst4_n = 1'b0; val1 = 1'b1; val4 = 1'b1;
        for (int l = 0; l < 8; l++) begin
            req1[l] = mk(1'b1, 32'h20 + l, 2'd0, 32'h55);
            req4[l] = mk(1'b1, 32'h20 + l, 2'd0, 32'h55);
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL reset_rdy1 got=%b exp=0", rdy1); end
            n_checks++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL reset_rdy4 got=%b exp=0", rdy4); end
            n_checks++; if (rv1 !== 8'h00) begin n_fail++; $display("FAIL reset_val got=%h exp=00", rv1); end
            n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err1); end
            for (int l = 0; l < 8; l++) begin
                n_checks++;
                if (resp1[l] !== 35'h0) begin n_fail++; $display("FAIL reset_msg lane%0d got=%h exp=0", l, resp1[l]); end
            end
        end
        for (int l = 0; l < 8; l++) req1[l] = mk(1'b0, 32'h20 + l, 2'd0, 32'h0);
        val4 = 1'b0;
        rst1_n = 1'b1; rst4_n = 1'b1;
        #1;
        n_checks++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL release_rdy got=%b exp=1", rdy1); end
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (rv1 !== 8'hFF) begin n_fail++; $display("FAIL first_accept_val got=%h exp=ff", rv1); end
        n_checks++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL first_accept_rdy got=%b exp=0", rdy1); end
        for (int l = 0; l < 8; l++) begin
            n_checks++;
            if (resp1[l][31:0] === 32'h55) begin n_fail++; $display("FAIL reset_no_write lane%0d got=%h exp=not 55", l, resp1[l][31:0]); end
        end
        val1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        for (int l = 0; l < 8; l++) req1[l] = mk(1'b1, 32'h10 + l, 2'd0, 32'hA0 + l);
        run1();
        n_checks++; if (gval !== 8'hFF) begin n_fail++; $display("FAIL wr_val got=%h exp=ff", gval); end
        for (int l = 0; l < 8; l++) begin
            n_checks++;
            if (got[l] !== {1'b1, 2'd0, 32'h0}) begin n_fail++; $display("FAIL wr_resp lane%0d got=%h exp=%h", l, got[l], {1'b1, 2'd0, 32'h0}); end
        end
        reads_around();
        run1();
        n_checks++; if (rdy_at_req !== 1'b1) begin n_fail++; $display("FAIL rd_rdy_idle got=%b exp=1", rdy_at_req); end
        n_checks++; if (rdy_in_resp !== 1'b0) begin n_fail++; $display("FAIL rd_rdy_resp got=%b exp=0", rdy_in_resp); end
        n_checks++; if (hval !== 8'h00) begin n_fail++; $display("FAIL val_one_cycle got=%h exp=00", hval); end
        for (int l = 0; l < 8; l++) begin
            n_checks++;
            if (got[l] !== {1'b0, 2'd0, 32'hA0 + l}) begin n_fail++; $display("FAIL rd_resp lane%0d got=%h exp=%h", l, got[l], 32'hA0 + l); end
            n_checks++;
            if (held[l] !== got[l]) begin n_fail++; $display("FAIL msg_hold lane%0d got=%h exp=%h", l, held[l], got[l]); end
        end
    endtask

    task automatic test_partial();
        reads_around();
        req1[0] = mk(1'b1, 32'd5, 2'd0, 32'h1122_3344); run1();
        req1[0] = mk(1'b1, 32'd5, 2'd1, 32'h0000_00FF); run1();
        req1[0] = mk(1'b0, 32'd5, 2'd3, 32'h0);         run1();
        n_checks++;
        if (got[0] !== {1'b0, 2'd3, 32'h1122_33FF}) begin n_fail++; $display("FAIL partial8 got=%h exp=%h", got[0], {1'b0, 2'd3, 32'h1122_33FF}); end
        req1[0] = mk(1'b1, 32'd5, 2'd2, 32'h9999_BEEF); run1();
        req1[0] = mk(1'b0, 32'd5, 2'd0, 32'h0);         run1();
        n_checks++;
        if (got[0][31:0] !== 32'h1122_BEEF) begin n_fail++; $display("FAIL partial16 got=%h exp=1122beef", got[0][31:0]); end
        for (int l = 1; l < 8; l++) begin
            n_checks++;
            if (got[l] !== exp_msg[l]) begin n_fail++; $display("FAIL partial_other lane%0d got=%h exp=%h", l, got[l], exp_msg[l]); end
        end
    endtask

    task automatic test_conflict();
        reads_around();
        req1[0] = mk(1'b1, 32'd9, 2'd0, 32'h1); run1();
        req1[0] = mk(1'b0, 32'd9, 2'd0, 32'h0);
        req1[2] = mk(1'b1, 32'd9, 2'd0, 32'h2);
        req1[6] = mk(1'b1, 32'd9, 2'd0, 32'h6);
        run1();
        n_checks++; if (got[0][31:0] !== 32'h1) begin n_fail++; $display("FAIL conflict_preread got=%h exp=1", got[0][31:0]); end
        n_checks++; if (got[6] !== {1'b1, 2'd0, 32'h0}) begin n_fail++; $display("FAIL conflict_wresp got=%h exp=%h", got[6], {1'b1, 2'd0, 32'h0}); end
        reads_around();
        req1[0] = mk(1'b0, 32'd9, 2'd0, 32'h0);
        run1();
        n_checks++; if (got[0][31:0] !== 32'h6) begin n_fail++; $display("FAIL conflict_winner got=%h exp=6", got[0][31:0]); end
    endtask

    task automatic test_latency4();
        for (int l = 0; l < 8; l++) req4[l] = mk(1'b1, 32'h40 + l, 2'd0, 32'hC0 + l);
        val4 = 1'b1;
        n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL lat4_rdy_idle got=%b exp=1", rdy4); end
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) val4 = 1'b0;
            n_checks++;
            if (rv4 !== ((k == 4) ? 8'hFF : 8'h00)) begin n_fail++; $display("FAIL lat4_val t+%0d got=%h", k, rv4); end
            n_checks++;
            if (rdy4 !== (k > 4)) begin n_fail++; $display("FAIL lat4_rdy t+%0d got=%b exp=%b", k, rdy4, (k > 4)); end
        end
        // Second transaction, interrupted by reset two cycles after accept.
        for (int l = 0; l < 8; l++) req4[l] = mk(1'b1, 32'h48 + l, 2'd0, 32'hD0 + l);
        val4 = 1'b1;
        @(posedge clk);
        @(negedge clk); val4 = 1'b0;
        @(negedge clk); rst4_n = 1'b0;
        #1;
        for (int k = 2; k <= 5; k++) begin
            n_checks++;
            if (rv4 !== 8'h00 || rdy4 !== 1'b0) begin n_fail++; $display("FAIL lat4_reset t+%0d val=%h rdy=%b exp=00/0", k, rv4, rdy4); end
            if (k < 5) @(negedge clk);
        end
        rst4_n = 1'b1;
        #1;
        n_checks++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL lat4_rdy_release got=%b exp=1", rdy4); end
        @(negedge clk);
        n_checks++; if (rv4 !== 8'h00) begin n_fail++; $display("FAIL lat4_no_pulse got=%h exp=00", rv4); end
        // Writes committed at the interrupted accept must still be present.
        for (int l = 0; l < 8; l++) req4[l] = mk(1'b0, 32'h48 + l, 2'd0, 32'h0);
        val4 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) val4 = 1'b0;
        end
        n_checks++; if (rv4 !== 8'hFF) begin n_fail++; $display("FAIL lat4_readback_val got=%h exp=ff", rv4); end
        for (int l = 0; l < 8; l++) begin
            n_checks++;
            if (resp4[l][31:0] !== 32'hD0 + l) begin n_fail++; $display("FAIL lat4_committed lane%0d got=%h exp=%h", l, resp4[l][31:0], 32'hD0 + l); end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int b = 0; b < 32; b++) begin
            for (int l = 0; l < 8; l++) req1[l] = mk(1'b1, 32'(b * 8 + l), 2'd0, $urandom);
            run1();
        end
        for (int t = 0; t < 60; t++) begin
            for (int l = 0; l < 8; l++) begin
                logic [31:0] a;
                a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom_range(0, 255));
                req1[l] = mk(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom);
            end
            run1();
            n_checks++; if (gval !== 8'hFF) begin n_fail++; $display("FAIL rand_val txn%0d got=%h exp=ff", t, gval); end
            for (int l = 0; l < 8; l++) begin
                n_checks++;
                if (got[l] !== exp_msg[l]) begin n_fail++; $display("FAIL rand_resp txn%0d lane%0d got=%h exp=%h", t, l, got[l], exp_msg[l]); end
            end
        end
        n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL rand_err got=%b exp=0", err1); end
    endtask

    task automatic test_errchk();
        logic [31:0] pre0;
        logic        exp_err;
        pre0 = mdl[0];
`ifdef RISCVVEC_LANE_MEM_ERRCHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        reads_around();
        req1[3] = mk(1'b1, 32'h100, 2'd0, 32'h77);
        run1();
        n_checks++; if (err1 !== exp_err) begin n_fail++; $display("FAIL oob_err got=%b exp=%b", err1, exp_err); end
        reads_around();
        req1[3] = mk(1'b0, 32'h100, 2'd0, 32'h0);
        req1[4] = mk(1'b0, 32'h0,   2'd0, 32'h0);
        run1();
`ifdef RISCVVEC_LANE_MEM_ERRCHK_EN
        n_checks++; if (got[3][31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL oob_read got=%h exp=deadbeef", got[3][31:0]); end
        n_checks++; if (got[4][31:0] !== pre0) begin n_fail++; $display("FAIL oob_nostore got=%h exp=%h", got[4][31:0], pre0); end
`else
        n_checks++; if (got[3][31:0] !== 32'h77) begin n_fail++; $display("FAIL alias_read got=%h exp=77 (was %h)", got[3][31:0], pre0); end
        n_checks++; if (got[4][31:0] !== 32'h77) begin n_fail++; $display("FAIL alias_store got=%h exp=77", got[4][31:0]); end
`endif
        for (int l = 0; l < 8; l++) begin
            n_checks++;
            if (got[l] !== exp_msg[l]) begin n_fail++; $display("FAIL oob_model lane%0d got=%h exp=%h", l, got[l], exp_msg[l]); end
        end
        n_checks++; if (err1 !== model_err) begin n_fail++; $display("FAIL oob_sticky got=%b exp=%b", err1, model_err); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial();
        test_conflict();
        test_latency4();
        test_random();
        test_errchk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/riscvvec_lane_mem_responder.md
# riscvvec_lane_mem_responder

Eight-lane data-memory responder for the vector core's lane-parallel memory ports: one shared request valid, eight per-lane request messages, and eight per-lane responses returned in the same cycle. It is the memory-side end of the core's dmemreq0..7 / dmemresp0..7 interface. It holds a word-indexed storage array and services one eight-lane transaction at a time with a fixed, parameterised latency. It is used as the test-harness data memory and as the behavioural model for the lane memory subsystem.

## Interface
- ENTRIES, 256: words of storage, power of two; index width IW = log2(ENTRIES).
- LATENCY, 1: cycles from request acceptance to response valid, must be ≥1.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- memreq_val  in  1  shared request valid for all eight lanes.
- memreq_rdy  out  1  responder can accept a transaction.
- memreqN_msg (N=0..7)  in  67  lane request message:
  - bits [66] type: 0 = read, 1 = write.
  - bits [65:34] addr: word index.
  - bits [33:32] len: 0 = 32 bits, 1 = 8 bits, 2 = 16 bits, 3 = 24 bits.
  - bits [31:0] data.
- memrespN_msg (N=0..7)  out  35  lane response message:
  - bits [34] type: echoed.
  - bits [33:32] len: echoed.
  - bits [31:0] data.
- memrespN_val (N=0..7)  out  1  lane response valid; all eight are driven identically. There is no response ready; the consumer must sink the response.
- err_oob  out  1  sticky out-of-range flag (see Configuration).

## Operation
- State machine has three states.
  - IDLE: memreq_rdy = 1.
    - memreq_val = 1: accept the transaction → WAIT if LATENCY > 1, else RESP.
    - memreq_val = 0: stay in IDLE.
  - WAIT: down-counter loaded with LATENCY-2 at accept; when the counter is 0 → RESP, else decrement.
  - RESP: memrespN_val = 1 for exactly one cycle → IDLE.
- Array access occurs entirely at the accept edge:
  - Per lane, index = addr[IW-1:0].
  - Read data for every read lane is captured into a per-lane response register.
  - All write lanes commit on the same edge.
  - Reads return pre-write contents even when another lane writes the same index in the same transaction.
- Partial writes: len = 1/2/3 replaces bits [7:0]/[15:0]/[23:0] of the word; the upper bits are retained. len = 0 replaces the full word.
- Write conflict (two lanes write the same index): the highest-numbered lane wins.
- Response data:
  - Read lanes return the full 32-bit word regardless of len.
  - Write lanes return 32'h0.
  - type and len are echoed from the request.
- A lane whose type is 0 is an ordinary read; the core uses this for inactive lanes beyond the vector length. It is serviced and its data is ignored by the core.
- Storage array is not reset; contents are X until written.

## Timing
- While reset is asserted:
  - memreq_rdy = 0.
  - All memrespN_val = 0.
  - All memrespN_msg = 0.
  - err_oob = 0.
  - State = IDLE.
- The first accept is possible on the first rising edge after reset deasserts.
- Handshake: a transaction transfers on a rising edge with memreq_val && memreq_rdy. Messages are sampled only on that edge.
- Latency: responses are valid exactly LATENCY cycles after the accept edge.
- memreq_rdy is 0 in WAIT and RESP. Back-to-back throughput is one transaction per LATENCY+1 cycles.
- memrespN_msg holds its value after RESP until the next response. Only val deasserts.
- Reset mid-transaction: the pending response is discarded and no val pulse is produced. Writes already committed at accept remain in storage.

## Configuration
- RISCVVEC_LANE_MEM_ERRCHK_EN defined:
  - Any lane with nonzero addr[31:IW] is out of range.
  - An out-of-range write is suppressed.
  - An out-of-range read returns 32'hDEADBEEF.
  - err_oob sets at the accept edge and stays set until reset.
  - In-range lanes of the same transaction proceed normally.
- Not defined:
  - Upper address bits are ignored and addresses alias modulo ENTRIES.
  - err_oob is tied to 0.

## Test plan
- Reset: hold reset low 3 cycles with memreq_val = 1 → rdy = 0, all val = 0, no array writes; first accept occurs on the edge after release.
- Write then read, LATENCY = 1:
  - Write lanes 0..7 at addr 0x10..0x17 with data 0xA0..0xA7 → all val pulse on the next cycle with data 0.
  - Read the same addresses → lane N returns 0xA0+N; rdy is low during the RESP cycle.
- Partial write: 0x11223344 at index 5, then a len = 1 write of 0xFF → a read of index 5 returns 0x112233FF. A len = 2 write of 0xBEEF → the read returns 0x1122BEEF.
- Conflict and ordering:
  - Lanes 2 and 6 write index 9 with 0x2 and 0x6, while lane 0 reads index 9 (prior value 0x1) in the same transaction → lane 0 returns 0x1.
  - A later read of index 9 returns 0x6.
- LATENCY = 4:
  - Accept at cycle t → val high at t+4 only.
  - rdy is low for t+1..t+4.
  - Asserting reset at t+2 → no val pulse, and rdy is 1 after release.
- Macro RISCVVEC_LANE_MEM_ERRCHK_EN, ENTRIES = 256: lane 3 writes addr 0x100 → no store, err_oob = 1. A lane 3 read of 0x100 → 32'hDEADBEEF. Without the macro, the same write lands at index 0 and err_oob stays 0.
